// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's access port (request, write data, grant, read return).
// Latency: gnt is combinational in the request cycle; rvalid/rdata arrive one cycle after a granted read.
// Backpressure: the requester holds req/we/lock/addr/wdata stable until it sees gnt.
interface mem_port_arbiter_if #(
  parameter int A_S = 10
);
  logic           req;
  logic           we;
  logic           lock;
  logic [A_S-1:0] addr;
  logic [31:0]    wdata;
  logic           gnt;
  logic           rvalid;
  logic [31:0]    rdata;

  // Requester side drives the access, arbiter side answers it.
  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM (comb read, sync write) between port A (LSU) and port B (debug/DMA).
// Latency: grant is combinational in the request cycle; read data/rvalid registered one cycle after a granted read.
// Backpressure: losers wait with request held; round-robin on conflict, bounded lock (MAX_LOCK) for RMW.
// Optional feature: define MEM_ARB_PERF_CNT_EN to add a_gnt_cnt/b_gnt_cnt/conflict_cnt counters.
module mem_port_arbiter #(
  parameter int ADDRESS_SIZE = 1024,
  parameter int A_S          = $clog2(ADDRESS_SIZE),
  parameter int MAX_LOCK     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   port_a,
  mem_port_arbiter_if.slave   port_b,
  output logic [A_S-1:0]      ram_address,
  output logic                ram_mem_write,
  output logic [31:0]         ram_write_data,
  input  logic [31:0]         ram_read_data
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         a_gnt_cnt,
  output logic [31:0]         b_gnt_cnt,
  output logic [31:0]         conflict_cnt
`endif
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  lock_cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [CW-1:0]  lock_cnt_inc;
  logic           last_b;       // 1 when B owned the most recent grant
  logic           gnt_a;
  logic           gnt_b;
  logic           rvalid_a;
  logic           rvalid_b;
  logic [31:0]    rdata_a;
  logic [31:0]    rdata_b;

  assign lock_cnt_inc = lock_cnt + CNT_ONE;

  // State register: FSM state, lock run length and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lock_cnt <= '0;
      last_b   <= 1'b1;
    end else begin
      state    <= state_nxt;
      lock_cnt <= cnt_nxt;
      if (gnt_a) begin
        last_b <= 1'b0;
      end else if (gnt_b) begin
        last_b <= 1'b1;
      end
    end
  end

  // Next state: enter a lock on a locked grant, leave it on unlock, abandon or run-length limit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        // With MAX_LOCK==1 a single locked grant already exhausts the lock.
        if (MAX_LOCK > 1) begin
          if (gnt_a && port_a.lock) begin
            state_nxt = ST_LOCK_A;
            cnt_nxt   = CNT_ONE;
          end else if (gnt_b && port_b.lock) begin
            state_nxt = ST_LOCK_B;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_LOCK_A: begin
        if (!gnt_a || !port_a.lock || (lock_cnt_inc == CNT_MAX)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = lock_cnt_inc;
        end
      end
      ST_LOCK_B: begin
        if (!gnt_b || !port_b.lock || (lock_cnt_inc == CNT_MAX)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = lock_cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: same-cycle grant decision and RAM pin steering; nothing granted while in reset.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (port_a.req && (!port_b.req || last_b)) begin
            gnt_a = 1'b1;
          end else if (port_b.req) begin
            gnt_b = 1'b1;
          end
        end
        ST_LOCK_A: gnt_a = port_a.req;
        ST_LOCK_B: gnt_b = port_b.req;
        default: begin
          gnt_a = 1'b0;
          gnt_b = 1'b0;
        end
      endcase
    end

    ram_address    = port_a.addr;
    ram_mem_write  = 1'b0;
    ram_write_data = port_a.wdata;
    if (gnt_a) begin
      ram_mem_write = port_a.we;
    end else if (gnt_b) begin
      ram_address    = port_b.addr;
      ram_mem_write  = port_b.we;
      ram_write_data = port_b.wdata;
    end
  end

  // Read return: capture RAM data at the edge ending a granted read; rvalid pulses one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= gnt_a && !port_a.we;
      rvalid_b <= gnt_b && !port_b.we;
      if (gnt_a && !port_a.we) begin
        rdata_a <= ram_read_data;
      end
      if (gnt_b && !port_b.we) begin
        rdata_b <= ram_read_data;
      end
    end
  end

  assign port_a.gnt    = gnt_a;
  assign port_b.gnt    = gnt_b;
  assign port_a.rvalid = rvalid_a;
  assign port_b.rvalid = rvalid_b;
  assign port_a.rdata  = rdata_a;
  assign port_b.rdata  = rdata_b;

`ifdef MEM_ARB_PERF_CNT_EN
  // Performance counters: grants per port and cycles with both ports requesting; free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_gnt_cnt    <= '0;
      b_gnt_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_a) begin
        a_gnt_cnt <= a_gnt_cnt + 32'd1;
      end
      if (gnt_b) begin
        b_gnt_cnt <= b_gnt_cnt + 32'd1;
      end
      if (port_a.req && port_b.req) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a RAM model and a port-level reference model.
// Latency: expectations pushed per issued cycle; monitor checks on the falling edge of the same/next cycle.
// Backpressure: stimulus holds a request until the reference model says it was granted.
module tb_mem_port_arbiter;

  localparam int ADDRESS_SIZE = 1024;
  localparam int A_S          = 10;
  localparam int MAX_LOCK     = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.A_S(A_S)) pa ();
  mem_port_arbiter_if #(.A_S(A_S)) pb ();

  logic [A_S-1:0] ram_address;
  logic           ram_mem_write;
  logic [31:0]    ram_write_data;
  logic [31:0]    ram_read_data;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]    a_gnt_cnt;
  logic [31:0]    b_gnt_cnt;
  logic [31:0]    conflict_cnt;
  int             perf_cyc = -1;
`endif

  mem_port_arbiter #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .A_S(A_S),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .port_a(pa),
    .port_b(pb),
    .ram_address(ram_address),
    .ram_mem_write(ram_mem_write),
    .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .a_gnt_cnt(a_gnt_cnt),
    .b_gnt_cnt(b_gnt_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  // RAM environment: combinational read, write on rising edge.
  logic [31:0] ram_mem [ADDRESS_SIZE];
  assign ram_read_data = ram_mem[ram_address];
  initial begin
    for (int i = 0; i < ADDRESS_SIZE; i++) ram_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
    forever begin
      @(posedge clk);
      if (ram_mem_write) ram_mem[ram_address] = ram_write_data;
    end
  end

  typedef struct {
    logic [1:0]     gnt;   // {a,b}
    logic           we;
    logic [A_S-1:0] addr;
    logic [31:0]    wdata;
  } gexp_t;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rqa[$];
  rexp_t rqb[$];

  // Reference model state: who holds a lock, how long, and who wins the next conflict.
  logic [31:0]    ref_mem [ADDRESS_SIZE];
  int             owner;
  int             run;
  int             prefer;
  logic           granted_last [2];

  logic           s_req [2];
  logic           s_we [2];
  logic           s_lock [2];
  logic [A_S-1:0] s_addr [2];
  logic [31:0]    s_wdata [2];

  int   cyc = 0;
  logic in_reset = 1'b1;
  logic done = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] hold_a = '0;
  logic [31:0] hold_b = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_port(int p, logic req, logic we, logic lock, logic [A_S-1:0] addr, logic [31:0] wdata);
    s_req[p] = req; s_we[p] = we; s_lock[p] = lock; s_addr[p] = addr; s_wdata[p] = wdata;
  endtask

  task automatic apply();
    pa.req = s_req[0]; pa.we = s_we[0]; pa.lock = s_lock[0]; pa.addr = s_addr[0]; pa.wdata = s_wdata[0];
    pb.req = s_req[1]; pb.we = s_we[1]; pb.lock = s_lock[1]; pb.addr = s_addr[1]; pb.wdata = s_wdata[1];
  endtask

  // One access cycle: drive the port requests and predict the cycle's outcome.
  task automatic step();
    int    w;
    gexp_t e;
    rexp_t r;
    @(posedge clk); #1;
    cyc++;
    apply();
    if (owner < 0) begin
      if (s_req[0] && s_req[1]) w = prefer;
      else if (s_req[0])        w = 0;
      else if (s_req[1])        w = 1;
      else                      w = -1;
    end else begin
      w = s_req[owner] ? owner : -1;
    end
    e.gnt   = (w == 0) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00;
    e.we    = (w >= 0) ? s_we[w] : 1'b0;
    e.addr  = (w >= 0) ? s_addr[w] : s_addr[0];
    e.wdata = (w >= 0) ? s_wdata[w] : 32'h0;
    gq.push_back(e);
    granted_last[0] = (w == 0);
    granted_last[1] = (w == 1);
    if (w >= 0) begin
      if (s_we[w]) begin
        ref_mem[s_addr[w]] = s_wdata[w];
      end else begin
        r.data = ref_mem[s_addr[w]];
        r.cyc  = cyc + 1;
        if (w == 0) rqa.push_back(r); else rqb.push_back(r);
      end
      prefer = 1 - w;
      if (s_lock[w]) begin
        run = (owner == w) ? run + 1 : 1;
        if (run >= MAX_LOCK) begin owner = -1; run = 0; end
        else owner = w;
      end else begin
        owner = -1; run = 0;
      end
    end else begin
      owner = -1; run = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    in_reset = 1'b1;
    gq.delete(); rqa.delete(); rqb.delete();
    owner = -1; run = 0; prefer = 0;
    granted_last[0] = 1'b0; granted_last[1] = 1'b0;
    // Requests raised during reset must still see no grant and no RAM write.
    pa.req = 1'b1; pa.we = 1'b1; pb.req = 1'b1; pb.we = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
    apply();
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant cycle or read return.
  always @(negedge clk) begin
    gexp_t e;
    rexp_t r;
    if (done) begin
      chk("grant_queue_drained", gq.size(), 0);
      chk("a_read_queue_drained", rqa.size(), 0);
      chk("b_read_queue_drained", rqb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (in_reset) begin
      hold_a = '0;
      hold_b = '0;
      chk("reset_gnt", {pa.gnt, pb.gnt}, 2'b00);
      chk("reset_mem_write", ram_mem_write, 1'b0);
      chk("reset_rvalid", {pa.rvalid, pb.rvalid}, 2'b00);
      chk("reset_a_rdata", pa.rdata, 32'h0);
      chk("reset_b_rdata", pb.rdata, 32'h0);
    end else begin
      if (gq.size() != 0) begin
        e = gq.pop_front();
        chk("gnt_ab", {pa.gnt, pb.gnt}, e.gnt);
        chk("ram_mem_write", ram_mem_write, e.we);
        chk("ram_address", ram_address, e.addr);
        if (e.we) chk("ram_write_data", ram_write_data, e.wdata);
      end
      if (rqa.size() != 0 && rqa[0].cyc < cyc) begin
        r = rqa.pop_front();
        chk("a_rvalid_missing_cycle", cyc, r.cyc);
      end
      if (rqb.size() != 0 && rqb[0].cyc < cyc) begin
        r = rqb.pop_front();
        chk("b_rvalid_missing_cycle", cyc, r.cyc);
      end
      if (pa.rvalid) begin
        if (rqa.size() == 0) chk("a_rvalid_unexpected", pa.rvalid, 1'b0);
        else begin
          r = rqa.pop_front();
          chk("a_rdata", pa.rdata, r.data);
          chk("a_rvalid_cycle", cyc, r.cyc);
          hold_a = r.data;
        end
      end else chk("a_rdata_hold", pa.rdata, hold_a);
      if (pb.rvalid) begin
        if (rqb.size() == 0) chk("b_rvalid_unexpected", pb.rvalid, 1'b0);
        else begin
          r = rqb.pop_front();
          chk("b_rdata", pb.rdata, r.data);
          chk("b_rvalid_cycle", cyc, r.cyc);
          hold_b = r.data;
        end
      end else chk("b_rdata_hold", pb.rdata, hold_b);
`ifdef MEM_ARB_PERF_CNT_EN
      if (cyc == perf_cyc) begin
        chk("a_gnt_cnt", a_gnt_cnt, 32'd3);
        chk("b_gnt_cnt", b_gnt_cnt, 32'd3);
        chk("conflict_cnt", conflict_cnt, 32'd6);
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed scenarios, then randomized traffic with held requests.
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < ADDRESS_SIZE; i++) ref_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
    apply();
    do_reset();

    // Both ports read back-to-back: alternate grants starting with A.
    set_port(0, 1'b1, 1'b0, 1'b0, 10'h005, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 10'h006, 32'h0);
    repeat (6) step();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
`ifdef MEM_ARB_PERF_CNT_EN
    perf_cyc = cyc + 1;
`endif
    step();

    // A writes then reads back 0x12.
    set_port(0, 1'b1, 1'b1, 1'b0, 10'h012, 32'hDEAD_BEEF);
    step();
    set_port(0, 1'b1, 1'b0, 1'b0, 10'h012, 32'h0);
    step();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    step();

    // B access first so A wins the next conflict, then A read-modify-write under lock.
    set_port(1, 1'b1, 1'b1, 1'b0, 10'h040, 32'h0BAD_F00D);
    step();
    set_port(0, 1'b1, 1'b0, 1'b1, 10'h003, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 10'h007, 32'h0);
    step();
    set_port(0, 1'b1, 1'b1, 1'b0, 10'h003, ref_mem[3] + 32'd1);
    step();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step();

    // A keeps its lock asserted against B: bounded run, then B, then A relocks.
    set_port(0, 1'b1, 1'b0, 1'b1, 10'h008, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 10'h009, 32'h0);
    repeat (7) step();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) step();

    // B locked reads, reset lands in the middle of the second one.
    set_port(1, 1'b1, 1'b0, 1'b1, 10'h010, 32'h0);
    step();
    set_port(0, 1'b1, 1'b0, 1'b0, 10'h001, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b1, 10'h011, 32'h0);
    step();
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 10'h001, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 10'h002, 32'h0);
    step();
    step();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step();

    // Random traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(s_req[p] && !granted_last[p])) begin
          set_port(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 2) == 0), A_S'($urandom_range(0, 15)), $urandom);
        end
      end
      step();
    end

    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) step();
    @(posedge clk); #1;
    done = 1'b1;
  end

endmodule
